wbdbgbus_link: RTL and testbench

- Byte-stream framing engine between the debug bus UART byte interfaces (uart_rx/uart_tx) and the 36-bit command/response streams of wbdbgbusmaster.
- Assembles 5-byte command frames and serialises 36-bit responses into 5-byte frames.
- Arbitrates a parametrised number of interrupt channels against responses, with fixed-priority or round-robin selection.
- It is the next-generation framing layer of the debug bus top level, replacing the hard-wired four-interrupt logic.

---
 rtl/wbdbgbus_link.sv | 217 +++++++++++++++++++++
 tb/tb_wbdbgbus_link.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdbgbus_link.sv
// Byte-stream framing between the debug-bus UART byte interfaces and the 36-bit
// command/response streams, with interrupt-vs-response arbitration on the TX side.
module wbdbgbus_link #(
  parameter int DROP_CLKS       = 2500000,
  parameter int NUM_IRQ         = 4,
  parameter bit IRQ_ROUND_ROBIN = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [35:0]        o_cmd_data,
  output logic               o_cmd_valid,
  input  logic               i_cmd_ready,
  output logic               o_cmd_reset,
  input  logic [35:0]        i_resp_data,
  input  logic               i_resp_valid,
  output logic               o_resp_ready,
  input  logic [NUM_IRQ-1:0] i_interrupts,
  output logic               o_cmd_drop,
  output logic               o_irq_lost
);

  localparam int TW = $clog2(DROP_CLKS + 1);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND0, ST_SEND1, ST_SEND2, ST_SEND3, ST_SEND4
  } tx_state_t;

  // ---------------------------------------------------------------- RX framer
  logic [31:0]   rx_shift;
  logic [2:0]    rx_idx;
  logic [TW-1:0] drop_timer;
  logic          rx_last;
  logic [35:0]   rx_frame;

  assign rx_last  = i_rx_valid && (rx_idx == 3'd4);
  assign rx_frame = {rx_shift[27:0], i_rx_data};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_shift   <= '0;
      rx_idx     <= '0;
      drop_timer <= TW'(DROP_CLKS);
    end else if (i_rx_valid) begin
      rx_shift   <= {rx_shift[23:0], i_rx_data};
      rx_idx     <= rx_last ? 3'd0 : rx_idx + 3'd1;
      drop_timer <= TW'(DROP_CLKS);
    end else if (rx_idx != 3'd0) begin
      // Partial frame went stale: forget it silently.
      if (drop_timer <= TW'(1)) begin
        rx_idx     <= '0;
        drop_timer <= TW'(DROP_CLKS);
      end else begin
        drop_timer <= drop_timer - TW'(1);
      end
    end
  end

  // ---------------------------------------------------------- command output
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cmd_data  <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_reset <= 1'b0;
      o_cmd_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the later frame-load override the
      // handshake clear below; the last <= in program order wins at the edge.
      o_cmd_reset <= 1'b0;
      o_cmd_drop  <= 1'b0;
      if (o_cmd_valid && i_cmd_ready) o_cmd_valid <= 1'b0;
      if (rx_last) begin
        if (rx_frame[35:32] == 4'hF) begin
          o_cmd_reset <= 1'b1;
          o_cmd_valid <= 1'b0;
        end else if (!o_cmd_valid || i_cmd_ready) begin
          o_cmd_data  <= rx_frame;
          o_cmd_valid <= 1'b1;
        end else begin
          o_cmd_drop  <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------ interrupt tracking
  logic [NUM_IRQ-1:0] irq_hist;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] irq_clr;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      irq_sel;
  logic               irq_any;

  assign irq_edge = i_interrupts & ~irq_hist;
  assign irq_any  = |pending;

  // History tracks the lines even in reset so levels held across reset never fire.
  always_ff @(posedge i_clk) begin
    irq_hist <= i_interrupts;
    if (!i_rst_n) begin
      pending    <= '0;
      o_irq_lost <= 1'b0;
    end else begin
      pending    <= (pending & ~irq_clr) | irq_edge;
      o_irq_lost <= |(irq_edge & pending & ~irq_clr);
    end
  end

  always_comb begin
    int   c;
    logic found;
    irq_sel = '0;
    found   = 1'b0;
    c       = 0;
    if (IRQ_ROUND_ROBIN) begin
      for (int i = 1; i <= NUM_IRQ; i++) begin
        c = int'(rr_ptr) + i;
        if (c >= NUM_IRQ) c = c - NUM_IRQ;
        if (!found && pending[IW'(c)]) begin
          irq_sel = IW'(c);
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pending[IW'(i)]) irq_sel = IW'(i);
      end
    end
  end

  // ------------------------------------------------------------------ TX FSM
  tx_state_t     state_q, state_d;
  logic          tx_valid_q, tx_valid_d;
  logic [35:0]   tx_frame_q, tx_frame_d;
  logic [IW-1:0] rr_ptr_d;
  logic [7:0]    tx_byte;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_frame_q <= '0;
      rr_ptr     <= IW'(NUM_IRQ - 1);
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_frame_q <= tx_frame_d;
      rr_ptr     <= rr_ptr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    tx_valid_d   = tx_valid_q;
    tx_frame_d   = tx_frame_q;
    rr_ptr_d     = rr_ptr;
    irq_clr      = '0;
    o_resp_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (irq_any) begin
          tx_frame_d = {4'b1000, 32'(irq_sel)};
          irq_clr    = NUM_IRQ'(1) << irq_sel;
          rr_ptr_d   = irq_sel;
          state_d    = ST_SEND0;
          tx_valid_d = 1'b1;
        end else begin
          o_resp_ready = 1'b1;
          if (i_resp_valid) begin
            tx_frame_d = i_resp_data;
            state_d    = ST_SEND0;
            tx_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // One dead cycle after each accepted byte before presenting the next.
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          case (state_q)
            ST_SEND0: state_d = ST_SEND1;
            ST_SEND1: state_d = ST_SEND2;
            ST_SEND2: state_d = ST_SEND3;
            ST_SEND3: state_d = ST_SEND4;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      ST_SEND0: tx_byte = {4'b0000, tx_frame_q[35:32]};
      ST_SEND1: tx_byte = tx_frame_q[31:24];
      ST_SEND2: tx_byte = tx_frame_q[23:16];
      ST_SEND3: tx_byte = tx_frame_q[15:8];
      ST_SEND4: tx_byte = tx_frame_q[7:0];
      default:  tx_byte = 8'h00;
    endcase
  end

  assign o_tx_valid = tx_valid_q;
  assign o_tx_data  = tx_valid_q ? tx_byte : 8'h00;

endmodule

// File: tb/tb_wbdbgbus_link.sv
// Self-checking bench for wbdbgbus_link: directed scenarios plus random traffic,
// all compared every cycle against a queue-based reference model.
module tb_wbdbgbus_link;

  localparam int DROP = 16;
  localparam int NIRQ = 8;
  localparam bit RR   = 1'b1;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [7:0]      i_rx_data;
  logic            i_rx_valid;
  logic [7:0]      o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_ready;
  logic [35:0]     o_cmd_data;
  logic            o_cmd_valid;
  logic            i_cmd_ready;
  logic            o_cmd_reset;
  logic [35:0]     i_resp_data;
  logic            i_resp_valid;
  logic            o_resp_ready;
  logic [NIRQ-1:0] i_interrupts;
  logic            o_cmd_drop;
  logic            o_irq_lost;

  always #5 i_clk = ~i_clk;

  wbdbgbus_link #(.DROP_CLKS(DROP), .NUM_IRQ(NIRQ), .IRQ_ROUND_ROBIN(RR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_cmd_data(o_cmd_data), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_reset(o_cmd_reset),
    .i_resp_data(i_resp_data), .i_resp_valid(i_resp_valid), .o_resp_ready(o_resp_ready),
    .i_interrupts(i_interrupts), .o_cmd_drop(o_cmd_drop), .o_irq_lost(o_irq_lost)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: frames as byte queues, interrupts as a bit set.
  logic [7:0]      m_rx_q[$];
  int              m_idle;
  logic            m_cmd_valid, m_cmd_reset, m_cmd_drop;
  logic [35:0]     m_cmd_data;
  logic [7:0]      m_tx_q[$];
  logic            m_tx_present;
  logic [NIRQ-1:0] m_pend, m_prev;
  int              m_ptr;
  logic            m_lost;
  logic            m_resp_taken;

  logic [7:0]  tx_log[$];
  logic [35:0] cmd_log[$];
  int n_reset_seen, n_drop_seen, n_lost_seen;

  task automatic model_step();
    logic [39:0]     f40;
    logic [NIRQ-1:0] edges, clr;
    int              ch;
    edges        = i_interrupts & ~m_prev;
    m_prev       = i_interrupts;
    m_resp_taken = 1'b0;
    if (!i_rst_n) begin
      m_rx_q.delete(); m_idle = 0;
      m_cmd_valid = 1'b0; m_cmd_data = '0; m_cmd_reset = 1'b0; m_cmd_drop = 1'b0;
      m_tx_q.delete(); m_tx_present = 1'b0;
      m_pend = '0; m_ptr = NIRQ - 1; m_lost = 1'b0;
      return;
    end
    // Command side
    m_cmd_reset = 1'b0;
    m_cmd_drop  = 1'b0;
    if (m_cmd_valid && i_cmd_ready) m_cmd_valid = 1'b0;
    if (i_rx_valid) begin
      m_idle = 0;
      m_rx_q.push_back(i_rx_data);
      if (m_rx_q.size() == 5) begin
        f40 = '0;
        foreach (m_rx_q[i]) f40 = {f40[31:0], m_rx_q[i]};
        m_rx_q.delete();
        if (f40[35:32] == 4'hF) begin
          m_cmd_reset = 1'b1;
          m_cmd_valid = 1'b0;
        end else if (!m_cmd_valid) begin
          m_cmd_valid = 1'b1;
          m_cmd_data  = f40[35:0];
        end else begin
          m_cmd_drop = 1'b1;
        end
      end
    end else if (m_rx_q.size() > 0) begin
      m_idle++;
      if (m_idle >= DROP) begin
        m_rx_q.delete();
        m_idle = 0;
      end
    end
    // Transmit side
    clr = '0;
    if (m_tx_q.size() > 0) begin
      if (m_tx_present && i_tx_ready) begin
        void'(m_tx_q.pop_front());
        m_tx_present = 1'b0;
      end else if (!m_tx_present) begin
        m_tx_present = 1'b1;
      end
    end else if (m_pend != '0) begin
      ch = -1;
      for (int i = 0; i < NIRQ; i++) begin
        int c;
        c = RR ? (m_ptr + 1 + i) % NIRQ : i;
        if (ch < 0 && m_pend[c]) ch = c;
      end
      clr[ch] = 1'b1;
      m_ptr = ch;
      m_tx_q.push_back(8'h08); m_tx_q.push_back(8'h00);
      m_tx_q.push_back(8'h00); m_tx_q.push_back(8'h00);
      m_tx_q.push_back(8'(ch));
      m_tx_present = 1'b1;
    end else if (i_resp_valid) begin
      m_resp_taken = 1'b1;
      m_tx_q.push_back({4'h0, i_resp_data[35:32]});
      m_tx_q.push_back(i_resp_data[31:24]);
      m_tx_q.push_back(i_resp_data[23:16]);
      m_tx_q.push_back(i_resp_data[15:8]);
      m_tx_q.push_back(i_resp_data[7:0]);
      m_tx_present = 1'b1;
    end
    m_lost = |(edges & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | edges;
  endtask

  task automatic compare_all();
    logic [7:0] exp_byte;
    exp_byte = m_tx_present ? m_tx_q[0] : 8'h00;
    check("cmd_valid",  64'(o_cmd_valid),  64'(m_cmd_valid));
    check("cmd_data",   64'(o_cmd_data),   64'(m_cmd_data));
    check("cmd_reset",  64'(o_cmd_reset),  64'(m_cmd_reset));
    check("cmd_drop",   64'(o_cmd_drop),   64'(m_cmd_drop));
    check("tx_valid",   64'(o_tx_valid),   64'(m_tx_present));
    check("tx_data",    64'(o_tx_data),    64'(exp_byte));
    check("resp_ready", 64'(o_resp_ready), 64'((m_tx_q.size() == 0) && (m_pend == '0)));
    check("irq_lost",   64'(o_irq_lost),   64'(m_lost));
  endtask

  task automatic tick();
    model_step();
    if (i_rst_n && o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
    if (i_rst_n && o_cmd_valid && i_cmd_ready) cmd_log.push_back(o_cmd_data);
    @(posedge i_clk);
    @(negedge i_clk);
    compare_all();
    if (o_cmd_reset) n_reset_seen++;
    if (o_cmd_drop)  n_drop_seen++;
    if (o_irq_lost)  n_lost_seen++;
    if (m_resp_taken) i_resp_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] exp5 [5]  = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] exp15[15] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h02,
                            8'h08, 8'h00, 8'h00, 8'h00, 8'h05,
                            8'h07, 8'hCA, 8'hFE, 8'h00, 8'h01};

  initial begin
    logic [31:0] r32;
    logic [3:0]  r4;
    int          gap;
    i_rst_n = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_tx_ready = 1'b0;
    i_cmd_ready = 1'b0; i_resp_data = '0; i_resp_valid = 1'b0; i_interrupts = '0;
    n_reset_seen = 0; n_drop_seen = 0; n_lost_seen = 0;
    m_prev = '0;
    @(negedge i_clk);

    // Reset state
    idle(2);
    check("rst_cmd_valid", 64'(o_cmd_valid), 64'd0);
    check("rst_tx_valid",  64'(o_tx_valid),  64'd0);
    i_rst_n = 1'b1;
    idle(2);

    // Basic command frame
    i_cmd_ready = 1'b1;
    cmd_log.delete();
    send_frame(40'h02_12_34_56_78);
    check("cmd_basic_valid", 64'(o_cmd_valid), 64'd1);
    check("cmd_basic_data",  64'(o_cmd_data),  64'h2_1234_5678);
    tick();
    check("cmd_basic_once", 64'(o_cmd_valid), 64'd0);

    // Reset frame (high nibble of byte 0 ignored), then timeout discard
    n_reset_seen = 0; n_drop_seen = 0;
    send_frame(40'hAF_00_00_00_00);
    idle(2);
    check("reset_pulses", 64'(n_reset_seen), 64'd1);
    cmd_log.delete();
    send_byte(8'h01); send_byte(8'h02);
    idle(DROP);
    send_frame(40'h01_00_00_00_05);
    tick();
    check("timeout_cmd_count", 64'(cmd_log.size()), 64'd1);
    if (cmd_log.size() > 0) check("timeout_cmd_data", 64'(cmd_log[0]), 64'h1_0000_0005);
    check("timeout_no_drop", 64'(n_drop_seen), 64'd0);

    // Backpressure: second frame dropped, first held then accepted once
    i_cmd_ready = 1'b0;
    cmd_log.delete();
    send_frame(40'h0A_11_22_33_44);
    send_frame(40'h0B_55_66_77_88);
    tick();
    check("bp_drop_pulses", 64'(n_drop_seen), 64'd1);
    check("bp_held_data",   64'(o_cmd_data),  64'hA_1122_3344);
    i_cmd_ready = 1'b1;
    idle(3);
    check("bp_accept_count", 64'(cmd_log.size()), 64'd1);
    if (cmd_log.size() > 0) check("bp_accept_data", 64'(cmd_log[0]), 64'hA_1122_3344);

    // Response serialisation under random tx_ready
    tx_log.delete();
    i_resp_data  = 36'h3_DEAD_BEEF;
    i_resp_valid = 1'b1;
    for (int k = 0; k < 300 && tx_log.size() < 5; k++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("resp_byte_count", 64'(tx_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < tx_log.size(); i++) check("resp_byte", 64'(tx_log[i]), 64'(exp5[i]));

    // Interrupts beat a waiting response; round robin order; lost edge
    i_tx_ready = 1'b1;
    idle(2);
    tx_log.delete();
    n_lost_seen  = 0;
    i_resp_data  = 36'h7_CAFE_0001;
    i_interrupts = 8'b0010_0100;
    tick();
    i_resp_valid = 1'b1;
    i_interrupts[5] = 1'b0;
    tick();
    i_interrupts[5] = 1'b1;
    tick();
    for (int k = 0; k < 200 && tx_log.size() < 15; k++) tick();
    check("irq_byte_count", 64'(tx_log.size()), 64'd15);
    for (int i = 0; i < 15 && i < tx_log.size(); i++) check("irq_byte", 64'(tx_log[i]), 64'(exp15[i]));
    check("irq_lost_pulses", 64'(n_lost_seen), 64'd1);
    i_interrupts = '0;
    idle(3);

    // Reset mid-TX
    tx_log.delete();
    i_resp_data  = 36'h9_0102_0304;
    i_resp_valid = 1'b1;
    for (int k = 0; k < 50 && tx_log.size() < 2; k++) tick();
    i_rst_n = 1'b0;
    tick();
    check("rst_tx_valid2", 64'(o_tx_valid), 64'd0);
    check("rst_tx_data2",  64'(o_tx_data),  64'd0);
    check("rst_cmd_data2", 64'(o_cmd_data), 64'd0);
    i_rst_n = 1'b1;
    idle(2);

    // Reset mid-RX with a line rising during reset
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    i_rst_n = 1'b0;
    i_interrupts[0] = 1'b1;
    tick();
    check("rst_rx_cmd_valid", 64'(o_cmd_valid), 64'd0);
    i_rst_n = 1'b1;
    cmd_log.delete();
    tx_log.delete();
    send_frame(40'h05_A5_5A_0F_F0);
    idle(10);
    check("post_rst_cmd_count", 64'(cmd_log.size()), 64'd1);
    if (cmd_log.size() > 0) check("post_rst_cmd_data", 64'(cmd_log[0]), 64'h5_A55A_0FF0);
    check("held_line_no_irq", 64'(tx_log.size()), 64'd0);
    i_interrupts = '0;
    idle(2);

    // Random traffic against the model
    gap = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      i_rst_n     = ($urandom_range(0, 699) != 0);
      i_cmd_ready = ($urandom_range(0, 3) != 0);
      i_tx_ready  = 1'($urandom_range(0, 1));
      if (gap > 0) begin
        gap--;
        i_rx_valid = 1'b0;
      end else begin
        i_rx_valid = 1'b1;
        i_rx_data  = 8'($urandom);
        gap = ($urandom_range(0, 19) == 0) ? $urandom_range(DROP - 2, DROP + 2) : $urandom_range(0, 3);
      end
      if (!i_resp_valid && $urandom_range(0, 7) == 0) begin
        r32 = $urandom;
        r4  = 4'($urandom);
        i_resp_data  = {r4, r32};
        i_resp_valid = 1'b1;
      end
      i_interrupts = i_interrupts ^ (8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom));
      tick();
      i_rx_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
